inv_sub_bytes_seq: RTL and testbench

Sequential AES InvSubBytes unit for the decryption datapath, the inverse of the forward S-box stage. It accepts a 128-bit AES state over a valid/ready handshake and substitutes every byte with the FIPS-197 inverse S-box, LANES bytes per clock. It returns the result over a second valid/ready handshake. It sits between InvShiftRows and AddRoundKey in the decryption round logic.

---
 rtl/aes_pkg.sv | 21 ++
 rtl/inv_sub_bytes_seq_if.sv | 22 ++
 rtl/inv_sbox.sv | 30 +++
 rtl/inv_sub_bytes_seq.sv | 109 ++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and constants for the decryption round datapath.
package aes_pkg;

    localparam int unsigned AES_STATE_W   = 128;
    localparam int unsigned AES_NUM_BYTES = 16;

    typedef logic [AES_STATE_W-1:0] aes_state_t;
    typedef logic [7:0]             aes_byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } inv_sub_state_e;

    // Byte 0 occupies the most significant octet of the state.
    function automatic int unsigned byte_lsb(int unsigned idx);
        return 8 * (AES_NUM_BYTES - 1 - idx);
    endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// Input/output valid-ready channels of the InvSubBytes unit.
interface inv_sub_bytes_seq_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_state_t in_state;
    logic       out_valid;
    logic       out_ready;
    aes_state_t out_state;
    logic       busy;

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy
    );

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/inv_sbox.sv
// FIPS-197 inverse S-box, purely combinational lookup.
module inv_sbox
    import aes_pkg::*;
(
    input  aes_byte_t i_byte,
    output aes_byte_t o_byte_c
);

    localparam aes_byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign o_byte_c = INV_SBOX[i_byte];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: substitutes LANES state bytes per clock between two valid/ready channels.
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inv_sub_bytes_seq_if.slave   io_bus
);

    localparam int unsigned NGRP  = AES_NUM_BYTES / LANES;
    localparam int unsigned CNT_W = (NGRP > 1) ? $clog2(NGRP) : 1;

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_BUSY = 2'(BUSY);
    localparam logic [1:0] S_DONE = 2'(DONE);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_sub_bytes_seq: LANES must be one of 1, 2, 4, 8, 16");
    end

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    aes_state_t       r_work;
    aes_state_t       w_work_nxt;
    aes_state_t       w_sub_work;
    logic             w_last;
    logic             w_in_ready_c;
    aes_byte_t        w_lane_in  [LANES];
    aes_byte_t        w_lane_out [LANES];

    // Select the current group of bytes and merge the substituted ones back.
    always_comb begin : p_lane_mux
        w_sub_work = r_work;
        for (int unsigned l = 0; l < LANES; l++) begin
            w_lane_in[l] = r_work[byte_lsb(32'(r_cnt) * LANES + l) +: 8];
            w_sub_work[byte_lsb(32'(r_cnt) * LANES + l) +: 8] = w_lane_out[l];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        inv_sbox u_inv_sbox (
            .i_byte   (w_lane_in[g]),
            .o_byte_c (w_lane_out[g])
        );
    end

    assign w_last = (r_cnt == CNT_W'(NGRP - 1));

    always_comb begin : p_fsm_comb
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_work_nxt   = r_work;
        w_in_ready_c = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready_c = rst_n;
                if (io_bus.in_valid && rst_n) begin
                    w_work_nxt  = io_bus.in_state;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                w_work_nxt = w_sub_work;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                // Draining the result frees the slot for a new state on the same edge.
                w_in_ready_c = io_bus.out_ready;
                if (io_bus.out_ready) begin
                    if (io_bus.in_valid) begin
                        w_work_nxt  = io_bus.in_state;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_BUSY;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_fsm_reg
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_work  <= w_work_nxt;
        end
    end

    assign io_bus.in_ready  = w_in_ready_c;
    assign io_bus.out_valid = (r_state == S_DONE);
    assign io_bus.busy      = (r_state == S_BUSY);
    assign io_bus.out_state = r_work;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq at LANES = 4, 1 and 16 against a GF(2^8)-derived inverse S-box model.
module tb_inv_sub_bytes_seq;
    import aes_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tb_in_valid  [3];
    aes_state_t tb_in_state  [3];
    logic       tb_out_ready [3];
    logic       tb_in_ready  [3];
    logic       tb_out_valid [3];
    aes_state_t tb_out_state [3];
    logic       tb_busy      [3];

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] fwd_ref [256];
    logic [7:0] inv_ref [256];

    always #5 clk = ~clk;

    inv_sub_bytes_seq_if u_if0 ();
    inv_sub_bytes_seq_if u_if1 ();
    inv_sub_bytes_seq_if u_if2 ();

    assign u_if0.in_valid  = tb_in_valid[0];
    assign u_if0.in_state  = tb_in_state[0];
    assign u_if0.out_ready = tb_out_ready[0];
    assign tb_in_ready[0]  = u_if0.in_ready;
    assign tb_out_valid[0] = u_if0.out_valid;
    assign tb_out_state[0] = u_if0.out_state;
    assign tb_busy[0]      = u_if0.busy;

    assign u_if1.in_valid  = tb_in_valid[1];
    assign u_if1.in_state  = tb_in_state[1];
    assign u_if1.out_ready = tb_out_ready[1];
    assign tb_in_ready[1]  = u_if1.in_ready;
    assign tb_out_valid[1] = u_if1.out_valid;
    assign tb_out_state[1] = u_if1.out_state;
    assign tb_busy[1]      = u_if1.busy;

    assign u_if2.in_valid  = tb_in_valid[2];
    assign u_if2.in_state  = tb_in_state[2];
    assign u_if2.out_ready = tb_out_ready[2];
    assign tb_in_ready[2]  = u_if2.in_ready;
    assign tb_out_valid[2] = u_if2.out_valid;
    assign tb_out_state[2] = u_if2.out_state;
    assign tb_busy[2]      = u_if2.busy;

    inv_sub_bytes_seq #(.LANES(4))  u_dut0 (.clk(clk), .rst_n(rst_n), .io_bus(u_if0));
    inv_sub_bytes_seq #(.LANES(1))  u_dut1 (.clk(clk), .rst_n(rst_n), .io_bus(u_if1));
    inv_sub_bytes_seq #(.LANES(16)) u_dut2 (.clk(clk), .rst_n(rst_n), .io_bus(u_if2));

    function automatic int lanes_of(int d);
        return (d == 0) ? 4 : ((d == 1) ? 1 : 16);
    endfunction

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(logic [7:0] b, int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // Forward S-box from multiplicative inverse plus affine map; inverse table by inverting it.
    task automatic build_model();
        logic [7:0] inv_x;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv_x = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv_x = 8'(y);
            s = inv_x ^ rotl8(inv_x, 1) ^ rotl8(inv_x, 2) ^ rotl8(inv_x, 3) ^ rotl8(inv_x, 4) ^ 8'h63;
            fwd_ref[x] = s;
            inv_ref[s] = 8'(x);
        end
    endtask

    function automatic aes_state_t model_inv(aes_state_t s);
        aes_state_t r = '0;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = inv_ref[s[127 - 8*i -: 8]];
        return r;
    endfunction

    function automatic aes_state_t rand_state();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer a state, then wait (bounded) until out_valid; returns at the negedge where it is seen.
    task automatic send_and_wait(int d, aes_state_t s, output int lat, output int busy_n, output bit ok);
        int t = 0;
        ok = 1'b1;
        lat = 0;
        busy_n = 0;
        tb_in_valid[d] = 1'b1;
        tb_in_state[d] = s;
        while (!tb_in_ready[d] && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (t >= 64) begin
            ok = 1'b0;
            tb_in_valid[d] = 1'b0;
            return;
        end
        @(negedge clk);
        tb_in_valid[d] = 1'b0;
        tb_in_state[d] = rand_state();
        forever begin
            if (tb_busy[d]) busy_n++;
            if (tb_out_valid[d]) break;
            if (lat >= 64) begin
                ok = 1'b0;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_vec(int d, aes_state_t din, aes_state_t dexp, string tag, bit chk_timing);
        int lat;
        int busy_n;
        bit ok;
        tb_out_ready[d] = 1'b1;
        send_and_wait(d, din, lat, busy_n, ok);
        check($sformatf("%s_done_d%0d", tag, d), 128'(ok), 128'(1));
        if (!ok) return;
        check($sformatf("%s_data_d%0d", tag, d), tb_out_state[d], dexp);
        if (chk_timing) begin
            check($sformatf("%s_latency_d%0d", tag, d), 128'(lat), 128'(16 / lanes_of(d)));
            check($sformatf("%s_busy_cycles_d%0d", tag, d), 128'(busy_n), 128'(16 / lanes_of(d)));
        end
        @(negedge clk);
        check($sformatf("%s_idle_after_d%0d", tag, d), {tb_out_valid[d], tb_in_ready[d]}, 2'b01);
    endtask

    typedef struct {
        aes_state_t din;
        aes_state_t dout;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t       vecs [3];
        aes_state_t a;
        aes_state_t b;
        aes_state_t s;
        aes_state_t e;
        int         lat;
        int         busy_n;
        int         lanes;
        bit         ok;
        bit         saw_valid;

        vecs[0].din  = {16{8'h63}};
        vecs[0].dout = '0;
        vecs[1].din  = {8'h7c, 8'h00, 8'h16, 8'h52, 8'hed, {11{8'h63}}};
        vecs[1].dout = {8'h01, 8'h52, 8'hff, 8'h48, 8'h53, {11{8'h00}}};
        vecs[2].din  = '0;
        vecs[2].dout = {16{8'h52}};

        build_model();

        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            tb_in_valid[d]  = 1'b0;
            tb_in_state[d]  = '0;
            tb_out_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++)
            check($sformatf("reset_outputs_d%0d", d), {tb_out_valid[d], tb_busy[d], tb_out_state[d]}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            check($sformatf("reset_in_ready_d%0d", d), 128'(tb_in_ready[d]), 128'(1));

        // Fixed vectors, forward-S-box sweep and random states on every lane width.
        for (int d = 0; d < 3; d++) begin
            for (int v = 0; v < 3; v++)
                run_vec(d, vecs[v].din, vecs[v].dout, $sformatf("vec%0d", v), 1'b1);
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < 16; j++) begin
                    s[127 - 8*j -: 8] = fwd_ref[16*i + j];
                    e[127 - 8*j -: 8] = 8'(16*i + j);
                end
                run_vec(d, s, e, $sformatf("sweep%0d", i), 1'b0);
            end
            for (int r = 0; r < 10; r++) begin
                s = rand_state();
                run_vec(d, s, model_inv(s), $sformatf("rand%0d", r), 1'b0);
            end
        end

        // Backpressure: result and flags hold while out_ready is low.
        tb_out_ready[0] = 1'b0;
        a = rand_state();
        send_and_wait(0, a, lat, busy_n, ok);
        check("bp_done", 128'(ok), 128'(1));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", c), {tb_out_valid[0], tb_in_ready[0], tb_out_state[0]},
                  {1'b1, 1'b0, model_inv(a)});
        end
        tb_out_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_release", {tb_out_valid[0], tb_in_ready[0], tb_busy[0]}, 3'b010);

        // Back-to-back: second state accepted on the edge that drains the first.
        for (int d = 0; d < 3; d++) begin
            lanes = lanes_of(d);
            a = rand_state();
            b = rand_state();
            tb_out_ready[d] = 1'b1;
            tb_in_valid[d]  = 1'b1;
            tb_in_state[d]  = a;
            @(negedge clk);
            tb_in_state[d] = b;
            lat = 0;
            while (!tb_out_valid[d] && lat < 64) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("b2b_first_d%0d", d), {tb_in_ready[d], tb_out_state[d]}, {1'b1, model_inv(a)});
            @(negedge clk);
            tb_in_valid[d] = 1'b0;
            tb_in_state[d] = rand_state();
            check($sformatf("b2b_reload_d%0d", d), {tb_out_valid[d], tb_busy[d]}, 2'b01);
            lat = 0;
            while (!tb_out_valid[d] && lat < 64) begin
                @(negedge clk);
                lat++;
            end
            check($sformatf("b2b_spacing_d%0d", d), 128'(lat), 128'(16 / lanes));
            check($sformatf("b2b_second_d%0d", d), tb_out_state[d], model_inv(b));
            @(negedge clk);
        end

        // Reset in the middle of BUSY discards the partial result.
        tb_out_ready[0] = 1'b1;
        tb_in_valid[0]  = 1'b1;
        tb_in_state[0]  = rand_state();
        @(negedge clk);
        tb_in_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_was_busy", 128'(tb_busy[0]), 128'(1));
        rst_n = 1'b0;
        #1;
        check("midrst_async", {tb_busy[0], tb_out_valid[0], tb_out_state[0]}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (tb_out_valid[0]) saw_valid = 1'b1;
        end
        check("midrst_no_pulse", 128'(saw_valid), 128'(0));
        check("midrst_idle", {tb_in_ready[0], tb_out_state[0]}, {1'b1, 128'h0});
        run_vec(0, vecs[1].din, vecs[1].dout, "midrst_after", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
